// File: rtl/param_seq_detector_if.sv
// Serial-stream bus for param_seq_detector: data, control and match outputs.
// master drives stimulus/config, slave is the detector.
interface param_seq_detector_if #(
  parameter int MAXLEN = 8,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 8
);
  logic              w;
  logic              en;
  logic              overlap;
  logic              load;
  logic [MAXLEN-1:0] pat_in;
  logic [LEN_W-1:0]  len_in;
  logic              clr_cnt;
  logic              z;
  logic [CNT_W-1:0]  match_cnt;

  modport master (
    output w, en, overlap, load,
    output pat_in, len_in, clr_cnt,
    input  z, match_cnt
  );

  modport slave (
    input  w, en, overlap, load,
    input  pat_in, len_in, clr_cnt,
    output z, match_cnt
  );
endinterface

// File: rtl/param_seq_detector.sv
// Programmable Mealy serial sequence detector, overlap/non-overlap modes.
// Optional saturating match counter enabled by SEQ_MATCH_COUNT_EN.
module param_seq_detector #(
  parameter int                MAXLEN  = 8,
  parameter int                LEN_W   = 4,
  parameter int                CNT_W   = 8,
  parameter logic [MAXLEN-1:0] RST_PAT = 8'b0000_1001,
  parameter int                RST_LEN = 4
) (
  input logic                  Clock,
  input logic                  Resetn,
  param_seq_detector_if.slave  bus
);

  localparam logic [LEN_W-1:0] LMAX = LEN_W'(MAXLEN);
  localparam logic [LEN_W-1:0] LMIN = LEN_W'(2);

  logic [MAXLEN-1:0] pat_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  fill;
  logic [MAXLEN-2:0] hist;
  logic [LEN_W-1:0]  len_cl;
  logic [MAXLEN-1:0] cand;
  logic [MAXLEN-1:0] mask;
  logic              full;
  logic              hit;

  always_comb begin
    len_cl = bus.len_in;
    if (bus.len_in < LMIN)
      len_cl = LMIN;
    else if (bus.len_in > LMAX)
      len_cl = LMAX;
  end

  // only the low len_q bits of the window take part
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAXLEN; i++)
      mask[i] = (LEN_W'(i) < len_q);
  end

  assign cand = {hist, bus.w};
  assign full = (fill >= len_q - LEN_W'(1));

  assign hit = Resetn & bus.en & ~bus.load & full
             & (((cand ^ pat_q) & mask) == '0);

  assign bus.z = hit;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pat_q <= RST_PAT;
      len_q <= LEN_W'(RST_LEN);
      hist  <= '0;
      fill  <= '0;
    end else if (bus.load) begin
      pat_q <= bus.pat_in;
      len_q <= len_cl;
      hist  <= '0;
      fill  <= '0;
    end else if (bus.en) begin
      hist <= cand[MAXLEN-2:0];
      // non-overlap: a match consumes its bits
      if (hit && !bus.overlap)
        fill <= '0;
      else if (fill != LMAX)
        fill <= fill + LEN_W'(1);
    end
  end

`ifdef SEQ_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      cnt <= '0;
    else if (bus.clr_cnt)
      cnt <= '0;
    else if (hit && cnt != '1)
      cnt <= cnt + CNT_W'(1);
  end

  assign bus.match_cnt = cnt;
`else
  assign bus.match_cnt = '0;
`endif

endmodule
